// File: rtl/display_mux_ctrl.sv
// Two-digit seven-segment multiplexer with blanking gaps; captures the operand
// pair once per frame so the digits and the LED sum always show the same values.
module display_mux_ctrl #(
  parameter int unsigned REFRESH_CNT = 20000,
  parameter int unsigned BLANK_CNT   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic       blank,
  output logic [3:0] digit,
  output logic       an0_n,
  output logic       an1_n,
  output logic [4:0] sum,
  output logic       frame_tick
);

  localparam int unsigned MAX_CNT = (REFRESH_CNT > BLANK_CNT) ? REFRESH_CNT : BLANK_CNT;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CNT - 1);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CNT - 1);

  typedef enum logic [1:0] {
    ST_BLANK0,
    ST_SHOW0,
    ST_BLANK1,
    ST_SHOW1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    s0_q;
  logic [3:0]    s1_q;
  logic [3:0]    digit_q;
  logic          an0_q;
  logic          an1_q;
  logic [4:0]    sum_q;
  logic          tick_q;
  logic          blank_done;
  logic          show_done;

  assign cnt_d      = cnt_q + CW'(1);
  assign blank_done = (cnt_q == BLANK_LAST);
  assign show_done  = (cnt_q == REFRESH_LAST);

  // Frame sequencer; every output change happens on a state transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK0;
      cnt_q   <= '0;
      s0_q    <= 4'h0;
      s1_q    <= 4'h0;
      digit_q <= 4'h0;
      an0_q   <= 1'b1;
      an1_q   <= 1'b1;
      sum_q   <= 5'h00;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        ST_BLANK0: begin
          if (blank_done) begin
            state_q <= ST_SHOW0;
            cnt_q   <= '0;
            s0_q    <= s0;
            s1_q    <= s1;
            sum_q   <= 5'(s0) + 5'(s1);
            digit_q <= s0;
            an0_q   <= 1'b0;
            tick_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_SHOW0: begin
          if (show_done) begin
            state_q <= ST_BLANK1;
            cnt_q   <= '0;
            an0_q   <= 1'b1;
            digit_q <= 4'h0;
          end else begin
            // Hold the latched operand; live s0 is ignored until the next capture.
            cnt_q   <= cnt_d;
            digit_q <= s0_q;
          end
        end
        ST_BLANK1: begin
          if (blank_done) begin
            state_q <= ST_SHOW1;
            cnt_q   <= '0;
            digit_q <= s1_q;
            an1_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_SHOW1: begin
          if (show_done) begin
            state_q <= ST_BLANK0;
            cnt_q   <= '0;
            an1_q   <= 1'b1;
            digit_q <= 4'h0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_BLANK0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // blank only gates the anodes, with no added latency.
  assign an0_n      = an0_q | blank;
  assign an1_n      = an1_q | blank;
  assign digit      = digit_q;
  assign sum        = sum_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed plus random checks of display_mux_ctrl against a frame-position model.
module tb_display_mux_ctrl;

  localparam int R = 4;
  localparam int B = 2;
  localparam int F = 2 * (B + R);

  logic       clk;
  logic       reset;
  logic [3:0] s0;
  logic [3:0] s1;
  logic       blank;
  logic [3:0] digit;
  logic       an0_n;
  logic       an1_n;
  logic [4:0] sum;
  logic       frame_tick;

  int         n_chk;
  int         n_fail;
  int         pos;
  logic [3:0] cap0;
  logic [3:0] cap1;
  logic [4:0] msum;

  display_mux_ctrl #(.REFRESH_CNT(R), .BLANK_CNT(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .s0         (s0),
    .s1         (s1),
    .blank      (blank),
    .digit      (digit),
    .an0_n      (an0_n),
    .an1_n      (an1_n),
    .sum        (sum),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int phase();
    return pos % F;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (pos=%0d)", tag, obs, exp, pos);
    end
  endtask

  task automatic check_all();
    int         ph;
    logic [3:0] e_digit;
    logic       in_show0;
    logic       in_show1;
    ph       = phase();
    in_show0 = (ph >= B) && (ph < B + R);
    in_show1 = (ph >= 2 * B + R);
    e_digit  = in_show0 ? cap0 : (in_show1 ? cap1 : 4'h0);
    chk("digit", 8'(digit), 8'(e_digit));
    chk("an0_n", 8'(an0_n), 8'(!in_show0 || blank));
    chk("an1_n", 8'(an1_n), 8'(!in_show1 || blank));
    chk("sum", 8'(sum), 8'(msum));
    chk("frame_tick", 8'(frame_tick), 8'(ph == B));
    chk("both_low", 8'(!an0_n && !an1_n), 8'h00);
  endtask

  // One clock: advance the model using the inputs sampled at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      pos  = 0;
      cap0 = 4'h0;
      cap1 = 4'h0;
      msum = 5'h00;
    end else begin
      pos++;
      if (pos % F == B) begin
        cap0 = s0;
        cap1 = s1;
        msum = 5'(s0) + 5'(s1);
      end
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < F && phase() != ph; i++) step();
    chk("phase_reached", 8'(phase()), 8'(ph));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    pos    = 0;
    cap0   = 4'h0;
    cap1   = 4'h0;
    msum   = 5'h00;
    reset  = 1'b1;
    blank  = 1'b0;
    s0     = 4'h9;
    s1     = 4'h7;

    run(3);
    reset = 1'b0;
    run(2 * F);

    // s1 changes during SHOW0: must not reach digit or sum until the next capture.
    run_to_phase(B + 1);
    s1 = 4'h2;
    run(2 * F);

    s0 = 4'hF;
    s1 = 4'hF;
    run(F + B + 1);
    s0 = 4'h0;
    s1 = 4'h0;
    run(F + 2);

    for (int i = 0; i < 60; i++) begin
      s0    = 4'($urandom_range(0, 15));
      s1    = 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 7) == 0);
      step();
    end
    blank = 1'b0;

    s0    = 4'h5;
    s1    = 4'hC;
    blank = 1'b1;
    run(30);
    run_to_phase(2 * B + R + 1);
    blank = 1'b0;
    #1;
    check_all();
    run(F);

    // Reset in the third SHOW1 cycle, then a full restart.
    run_to_phase(2 * B + R + 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(2 * F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
